mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port instruction/data memory between the fetch stage (IF) and the load/store
//  path (LS, driven by LW/SW decode). Arbitrates requests, sequences the memory access over
//  MEM_LATENCY cycles and routes the read data back to the requester. One transaction is in flight
//  at a time. A branch/flush can squash an in-flight fetch response.
// PARAMETERS
//  ADDR_WIDTH      32  byte address width
//  DATA_WIDTH      32  memory word width
//  MEM_LATENCY     1   cycles from mem_en to valid mem_rdata; legal range >= 1
//  MAX_DATA_BURST  4   consecutive LS grants allowed while IF waits before IF is forced; legal range >= 1
// PORTS
//  clk        in   1           clock
//  rst        in   1           reset: synchronous, active-high
//  if_req     in   1           fetch request
//  if_addr    in   ADDR_WIDTH  fetch address
//  if_flush   in   1           squash the outstanding fetch response
//  if_ready   out  1           fetch request accepted this cycle
//  if_rvalid  out  1           fetch data valid (1-cycle pulse)
//  if_rdata   out  DATA_WIDTH  fetch data
//  ls_req     in   1           load/store request
//  ls_we      in   1           1 = store, 0 = load
//  ls_addr    in   ADDR_WIDTH  load/store address
//  ls_wdata   in   DATA_WIDTH  store data
//  ls_ready   out  1           LS request accepted this cycle
//  ls_rvalid  out  1           load data valid / store done (1-cycle pulse)
//  ls_rdata   out  DATA_WIDTH  load data (0 for stores)
//  mem_en     out  1           memory access strobe (1 cycle per transaction)
//  mem_we     out  1           memory write enable
//  mem_addr   out  ADDR_WIDTH  memory address
//  mem_wdata  out  DATA_WIDTH  memory write data
//  mem_rdata  in   DATA_WIDTH  memory read data; valid MEM_LATENCY cycles after mem_en
// BEHAVIOUR
//  - Reset: FSM = IDLE; burst counter = 0; flush flag = 0; every output = 0.
//  - FSM states:
//    - IDLE  -> ISSUE on a handshake.
//    - ISSUE -> WAIT, or -> RESP directly when MEM_LATENCY == 1.
//    - WAIT  -> RESP after MEM_LATENCY-1 cycles.
//    - RESP  -> IDLE.
//  - Handshake: *_ready is asserted only in IDLE, and at most one of if_ready / ls_ready per cycle.
//    - A request is accepted when req & ready.
//    - The requester must hold req, addr, we and wdata stable until it is accepted.
//  - Grant rule in IDLE:
//    - If only one requester is active, grant it.
//    - If both are active, grant LS, unless burst_cnt == MAX_DATA_BURST, in which case grant IF.
//  - burst_cnt (saturating at MAX_DATA_BURST):
//    - +1 on an LS grant while if_req = 1.
//    - Cleared on any IF grant.
//    - Cleared on an LS grant while if_req = 0.
//  - Address, we and wdata are latched on accept; the owner (IF/LS) is latched in a 1-bit register.
//  - ISSUE: mem_en = 1 for exactly one cycle with the latched mem_we/addr/wdata.
//    - mem_we = 0 for all IF transactions.
//    - mem_* = 0 outside ISSUE.
//  - RESP (the cycle mem_rdata is valid): the owner's rvalid = 1 for one cycle.
//    - Loads/fetches: rdata = mem_rdata (combinational pass-through).
//    - Stores: ls_rvalid still pulses, with ls_rdata = 0.
//    - A non-owner's rvalid and rdata are 0.
//  - Timing: accept at cycle T -> mem_en at T+1 -> rvalid at T+1+MEM_LATENCY -> next accept earliest
//    at T+2+MEM_LATENCY.
//  - Flush:
//    - if_flush = 1 in any cycle from the IF accept through RESP (inclusive) sets a sticky flag,
//      which suppresses if_rvalid for that transaction. The memory access still completes.
//    - The flag clears on entry to IDLE.
//    - if_flush has no effect on LS transactions, and none in IDLE.
//    - In IDLE, if_flush = 1 together with if_req still allows the new fetch to be accepted.
//  - Reset mid-transaction: returns to IDLE next cycle; pending response dropped (no rvalid);
//    mem_en deasserted.
// TESTING
//  - Reset: after rst, hold both req=0 for 3 cycles -> all outputs 0, if_ready=ls_ready=0.
//  - Single fetch, MEM_LATENCY=1: if_req at addr 0x40, mem returns 0x00500093 ->
//    if_ready at T, mem_en/mem_addr=0x40 at T+1, if_rvalid with data 0x00500093 at T+2.
//  - Store then load: SW 0xDEADBEEF to 0x100, then LW 0x100 ->
//    mem_we=1 only on the store ISSUE, ls_rvalid pulses twice, second ls_rdata=0xDEADBEEF.
//  - Contention: if_req and ls_req held high continuously ->
//    grants LS,LS,LS,LS,IF,LS,... (MAX_DATA_BURST=4) and IF is never starved.
//  - Flush: assert if_flush in the WAIT cycle of a fetch (MEM_LATENCY=3) ->
//    mem_en still pulses, no if_rvalid, next request accepted on schedule.
//  - Reset mid-WAIT of a load -> no ls_rvalid, IDLE next cycle, fresh request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF) and load/store (LS).
// One transaction in flight; LS has priority, but IF is forced after MAX_DATA_BURST LS grants.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_LATENCY    = 1,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_ready,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_ready,
  output logic                  ls_rvalid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int BW = $clog2(MAX_DATA_BURST + 1);
  localparam int WW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);
  localparam logic [WW-1:0] WAIT_LAST = WW'((MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0);

  state_t                state, next_state;
  logic [BW-1:0]         burst_cnt;
  logic [WW-1:0]         wait_cnt;
  logic                  owner_if;
  logic                  we_q;
  logic                  flush_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  grant_if, grant_ls, accept;

  always_comb begin
    grant_if = if_req && (!ls_req || (burst_cnt == BURST_MAX));
    grant_ls = ls_req && !grant_if;
    accept   = (state == IDLE) && (grant_if || grant_ls);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (accept) next_state = ISSUE;
      ISSUE: next_state = (MEM_LATENCY == 1) ? RESP : WAIT;
      WAIT:  if (wait_cnt == WAIT_LAST) next_state = RESP;
      RESP:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
      wait_cnt  <= '0;
      owner_if  <= 1'b0;
      we_q      <= 1'b0;
      flush_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      if (accept) begin
        owner_if <= grant_if;
        we_q     <= grant_ls && ls_we;
        addr_q   <= grant_if ? if_addr : ls_addr;
        wdata_q  <= grant_ls ? ls_wdata : '0;
        // Burst only grows while IF is actually waiting behind LS.
        if (grant_if || !if_req)        burst_cnt <= '0;
        else if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + BW'(1);
      end
      if (state == WAIT) wait_cnt <= wait_cnt + WW'(1);
      else               wait_cnt <= '0;
      if (state == RESP)
        flush_q <= 1'b0;
      else if (if_flush && ((accept && grant_if) || (state != IDLE && owner_if)))
        flush_q <= 1'b1;
    end
  end

  always_comb begin
    if_ready  = 1'b0;
    ls_ready  = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    ls_rvalid = 1'b0;
    ls_rdata  = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if_ready = grant_if;
          ls_ready = grant_ls;
        end
        ISSUE: begin
          mem_en    = 1'b1;
          mem_we    = we_q;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
        end
        WAIT: ;
        RESP: begin
          if (owner_if) begin
            // A flush arriving in the response cycle itself still squashes it.
            if (!flush_q && !if_flush) begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end
          end else begin
            ls_rvalid = 1'b1;
            ls_rdata  = we_q ? '0 : mem_rdata;
          end
        end
      endcase
    end
  end

endmodule
